// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit driving the HI/LO registers.
// Radix-2 Booth multiply and signed restoring divide, one step per cycle.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH + 2;

    typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, FINISH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               quo_neg_q, quo_neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               zdiv_q, zdiv_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    // Datapath step results
    logic [WIDTH:0]     upper;
    logic [ACC_W-1:0]   acc_step;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               last_step;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvsr_d     = dvsr_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        zdiv_d     = zdiv_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        // Booth: upper half kept one bit wider so -2^(W-1) multiplicands cannot overflow
        upper = acc_q[ACC_W-1:WIDTH+1];
        unique case (acc_q[1:0])
            2'b01:   upper = upper + {mcand_q[WIDTH-1], mcand_q};
            2'b10:   upper = upper - {mcand_q[WIDTH-1], mcand_q};
            default: upper = acc_q[ACC_W-1:WIDTH+1];
        endcase
        acc_step = {upper[WIDTH], upper, acc_q[WIDTH:1]};

        // Restoring divide on magnitudes; remainder stays below divisor
        rem_sh   = {rem_q, quo_q[WIDTH-1]};
        diff     = rem_sh - {1'b0, dvsr_q};
        rem_step = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        last_step = (cnt_q == CNT_W'(WIDTH - 1));

        unique case (state_q)
            IDLE: begin
                if (mult_start) begin
                    mcand_d = a;
                    acc_d   = {(WIDTH + 1)'(0), b, 1'b0};
                    cnt_d   = '0;
                    zdiv_d  = 1'b0;
                    state_d = MULT_RUN;
                end else if (div_start) begin
                    if (b != '0) begin
                        quo_d     = a[WIDTH-1] ? -a : a;
                        dvsr_d    = b[WIDTH-1] ? -b : b;
                        rem_d     = '0;
                        quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
                        rem_neg_d = a[WIDTH-1];
                        cnt_d     = '0;
                        zdiv_d    = 1'b0;
                        state_d   = DIV_RUN;
                    end else begin
                        zdiv_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            MULT_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = acc_step[2*WIDTH:WIDTH+1];
                    lo_d    = acc_step[WIDTH:1];
                    state_d = FINISH;
                end
            end
            DIV_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_step) begin
                    hi_d    = rem_neg_q ? -rem_step : rem_step;
                    lo_d    = quo_neg_q ? -quo_step : quo_step;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == MULT_RUN) || (state_d == DIV_RUN);
        done_d     = (state_d == FINISH);
        div_zero_d = (state_d == FINISH) && zdiv_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            zdiv_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            zdiv_q     <= zdiv_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random model-checked ops,
// and hand-written restart / mid-operation reset sequences.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
    } exp_t;

    typedef struct {
        bit          mul;
        bit          dv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
    } vec_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] prev_hi  = '0;
    logic [31:0] prev_lo  = '0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic exp_t model(input bit mul, input logic [31:0] av, input logic [31:0] bv);
        exp_t        e;
        logic [63:0] p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = av;
        sbv = bv;
        e.dz  = 1'b0;
        e.lat = 33;
        if (mul) begin
            p    = 64'(longint'(sa) * longint'(sbv));
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (bv == '0) begin
            e.hi  = prev_hi;
            e.lo  = prev_lo;
            e.dz  = 1'b1;
            e.lat = 1;
        end else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
            e.hi = '0;
            e.lo = 32'h8000_0000;
        end else begin
            e.lo = 32'(sa / sbv);
            e.hi = 32'(sa % sbv);
        end
        return e;
    endfunction

    // Drive one command, optionally re-poke both starts mid-run, then compare at done
    task automatic run_op(input bit mul, input bit dv, input logic [31:0] av,
                          input logic [31:0] bv, input int poke, input string name);
        exp_t e;
        int   n;
        bit   busy_seen;
        @(negedge clk);
        a = av;
        b = bv;
        mult_start = mul;
        div_start  = dv;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = $urandom;
        b = $urandom;
        n = 1;
        busy_seen = busy;
        while (!done && n < 100) begin
            mult_start = (n == poke);
            div_start  = (n == poke);
            @(posedge clk);
            #1;
            n++;
            busy_seen |= busy;
        end
        mult_start = 1'b0;
        div_start  = 1'b0;
        if (sbq.size() == 0) begin
            $display("FAIL %s_sb: scoreboard empty", name);
            n_checks++;
            return;
        end
        e = sbq.pop_front();
        check({name, "_lat"}, 64'(n), 64'(e.lat));
        check({name, "_hi"}, 64'(hi), 64'(e.hi));
        check({name, "_lo"}, 64'(lo), 64'(e.lo));
        check({name, "_dz"}, 64'(div_zero), 64'(e.dz));
        check({name, "_busy_at_done"}, 64'(busy), 64'(0));
        check({name, "_busy_seen"}, 64'(busy_seen), 64'(!e.dz));
        prev_hi = e.hi;
        prev_lo = e.lo;
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, 64'({done, div_zero}), 64'(0));
    endtask

    vec_t vecs[8];

    initial begin
        exp_t e;
        int   done_cnt;

        vecs[0] = '{1'b1, 1'b0, 32'd6,          32'd7,          32'h0000_0000, 32'h0000_002A, 1'b0, 33};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 33};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 33};
        vecs[3] = '{1'b1, 1'b1, 32'd6,          32'd7,          32'h0000_0000, 32'h0000_002A, 1'b0, 33};
        vecs[4] = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33};
        vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 33};
        vecs[6] = '{1'b0, 1'b1, 32'd17,         32'd5,          32'h0000_0002, 32'h0000_0003, 1'b0, 33};
        vecs[7] = '{1'b0, 1'b1, 32'h1234_5678, 32'd0,          32'h0000_0002, 32'h0000_0003, 1'b1, 1};

        reset = 1'b0;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {hi, lo}, 64'(0));
        check("reset_flags", 64'({busy, done, div_zero}), 64'(0));
        reset = 1'b1;
        a = 32'd99;
        b = 32'd3;
        repeat (4) @(posedge clk);
        #1;
        check("idle_state", {hi, lo}, 64'(0));
        check("idle_flags", 64'({busy, done, div_zero}), 64'(0));

        for (int i = 0; i < 8; i++) begin
            e.hi  = vecs[i].hi;
            e.lo  = vecs[i].lo;
            e.dz  = vecs[i].dz;
            e.lat = vecs[i].lat;
            sbq.push_back(e);
            run_op(vecs[i].mul, vecs[i].dv, vecs[i].a, vecs[i].b, 0, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            bit          rm;
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom);
            rm = (i % 2 == 0);
            sbq.push_back(model(rm, ra, rb));
            run_op(rm, !rm, ra, rb, 0, $sformatf("rnd%0d", i));
        end

        // Restart attempt mid-multiply must be ignored
        sbq.push_back(model(1'b1, 32'd123, 32'hFFFF_FFFC));
        run_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFFC, 10, "restart_ignored");

        // Reset at iteration 10 of a divide aborts it with no done pulse
        @(negedge clk);
        a = 32'd100;
        b = 32'd7;
        div_start = 1'b1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_before_reset", 64'(busy), 64'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_state", {hi, lo}, 64'(0));
        check("abort_flags", 64'({busy, done, div_zero}), 64'(0));
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'(0));
        prev_hi = '0;
        prev_lo = '0;

        sbq.push_back(model(1'b1, 32'd6, 32'd7));
        run_op(1'b1, 1'b0, 32'd6, 32'd7, 0, "after_abort");

        check("sb_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
